// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus memory-side port of the shared memory arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              x_req;
  logic              x_r_wbar;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic              x_ack;
  logic [DATA_W-1:0] x_rdata;
  logic              mem_en;
  logic              mem_r_wbar;
  logic [ADDR_W-1:0] mem_ao;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport master (
    output f_req, f_addr, x_req, x_r_wbar, x_addr, x_wdata, mem_rdata,
    input  f_ack, f_rdata, x_ack, x_rdata, mem_en, mem_r_wbar, mem_ao, mem_wdata, busy
  );
  modport slave (
    input  f_req, f_addr, x_req, x_r_wbar, x_addr, x_wdata, mem_rdata,
    output f_ack, f_rdata, x_ack, x_rdata, mem_en, mem_r_wbar, mem_ao, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and execute with fixed-latency access.
// Define ARB_FAIR_EN to let a pending fetch win after FAIR_LIMIT consecutive execute grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int FAIR_LIMIT = 3
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              own_x_q, own_x_d;
  logic              en_q, en_d, rw_q, rw_d, busy_q, busy_d;
  logic              fack_q, fack_d, xack_q, xack_d;
  logic [ADDR_W-1:0] ao_q, ao_d;
  logic [DATA_W-1:0] wd_q, wd_d, frd_q, frd_d, xrd_q, xrd_d;
  logic              any_req, grant_x;
  assign any_req = bus.f_req || bus.x_req;
`ifdef ARB_FAIR_EN
  localparam int FW = FAIR_LIMIT > 0 ? $clog2(FAIR_LIMIT + 1) : 1;
  logic [FW-1:0] fair_q, fair_d;
  assign grant_x = bus.x_req && !(bus.f_req && fair_q == FW'(FAIR_LIMIT));
  // counts execute grants that overtook a waiting fetch
  assign fair_d  = (state_q == IDLE && any_req) ? ((grant_x && bus.f_req) ? fair_q + 1'b1 : '0) : fair_q;
  always_ff @(posedge clock)
    if (reset) fair_q <= '0;
    else fair_q <= fair_d;
`else
  assign grant_x = bus.x_req;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_x_d = own_x_q;
    en_d    = en_q;
    rw_d    = rw_q;
    ao_d    = ao_q;
    wd_d    = wd_q;
    frd_d   = frd_q;
    xrd_d   = xrd_q;
    fack_d  = 1'b0;
    xack_d  = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = ACCESS;
        own_x_d = grant_x;
        en_d    = 1'b1;
        rw_d    = grant_x ? bus.x_r_wbar : 1'b1;
        ao_d    = grant_x ? bus.x_addr : bus.f_addr;
        wd_d    = grant_x ? bus.x_wdata : '0;
        cnt_d   = 4'(MEM_LAT);
      end
      ACCESS: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = ACK;
        en_d    = 1'b0;
        fack_d  = !own_x_q;
        xack_d  = own_x_q;
        frd_d   = (rw_q && !own_x_q) ? bus.mem_rdata : frd_q;
        xrd_d   = (rw_q && own_x_q) ? bus.mem_rdata : xrd_q;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_x_q <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b1;
      ao_q    <= '0;
      wd_q    <= '0;
      frd_q   <= '0;
      xrd_q   <= '0;
      fack_q  <= 1'b0;
      xack_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_x_q <= own_x_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      ao_q    <= ao_d;
      wd_q    <= wd_d;
      frd_q   <= frd_d;
      xrd_q   <= xrd_d;
      fack_q  <= fack_d;
      xack_q  <= xack_d;
      busy_q  <= busy_d;
    end
  assign bus.mem_en     = en_q;
  assign bus.mem_r_wbar = rw_q;
  assign bus.mem_ao     = ao_q;
  assign bus.mem_wdata  = wd_q;
  assign bus.f_ack      = fack_q;
  assign bus.x_ack      = xack_q;
  assign bus.f_rdata    = frd_q;
  assign bus.x_rdata    = xrd_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model of the arbiter checked against directed and random traffic.
module tb_mem_port_arbiter;
  localparam int ML = 1, FL = 3, L1 = ML + 2, L2 = 2 * ML + 5;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b1;
  int          checks = 0, failures = 0, mfair = 0;
  logic [15:0] mem [32];
  logic [15:0] ref_mem [32];
  logic [15:0] m_frd = '0, m_xrd = '0;
  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bus ();
  mem_port_arbiter #(.ADDR_W(5), .DATA_W(16), .MEM_LAT(ML), .FAIR_LIMIT(FL)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  function automatic logic [15:0] init_val(input int i);
    return 16'hA5C3 ^ 16'((i - 4) * 16'h3B1D);
  endfunction
  assign bus.mem_rdata = mem[bus.mem_ao];
  always @(posedge clock)
    if (reset) for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    else if (bus.mem_en && !bus.mem_r_wbar) mem[bus.mem_ao] <= bus.mem_wdata;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    m_frd = '0;
    m_xrd = '0;
    mfair = 0;
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_f_ack"}, bus.f_ack, 0);
    chk({tag, "_x_ack"}, bus.x_ack, 0);
    chk({tag, "_f_rdata"}, bus.f_rdata, m_frd);
    chk({tag, "_x_rdata"}, bus.x_rdata, m_xrd);
  endtask
  // One episode: raise the chosen requests, hold each until its ack, check timing, order and data
  task automatic xact(input logic fr, xr, xrw, input logic [4:0] fa, xa, input logic [15:0] xd);
    int fat = 0, xat = 0;
    logic x_first;
    logic [15:0] ef, ex;
    x_first = xr && !(FAIR && fr && mfair == FL);
    if (x_first && !xrw) ref_mem[xa] = xd;
    ef = ref_mem[fa];
    if (xr && xrw) ex = ref_mem[xa];
    else if (xr) ref_mem[xa] = xd;
    if (x_first) mfair = fr ? mfair + 1 : 0;
    if (fr || xr) mfair = 0;
    bus.f_req = fr; bus.f_addr = fa;
    bus.x_req = xr; bus.x_addr = xa; bus.x_r_wbar = xrw; bus.x_wdata = xd;
    for (int n = 1; n <= 40 && ((fr && fat == 0) || (xr && xat == 0)); n++) begin
      step();
      if (bus.f_ack && bus.x_ack) chk("ack_overlap", 1, 0);
      if (n == 1) begin
        chk("grant_mem_en", bus.mem_en, 1);
        chk("grant_busy", bus.busy, 1);
        chk("grant_ao", bus.mem_ao, x_first ? xa : fa);
        chk("grant_rw", bus.mem_r_wbar, x_first ? xrw : 1'b1);
        chk("grant_wdata", bus.mem_wdata, x_first ? xd : 16'h0);
      end
      if (bus.f_ack) begin
        fat = n; bus.f_req = 1'b0; m_frd = ef;
        chk("f_rdata", bus.f_rdata, m_frd);
        chk("f_ack_mem_en", bus.mem_en, 0);
      end
      if (bus.x_ack) begin
        xat = n; bus.x_req = 1'b0;
        if (xrw) m_xrd = ex;
        chk("x_rdata", bus.x_rdata, m_xrd);
        chk("x_ack_mem_en", bus.mem_en, 0);
      end
    end
    if (fr) chk("f_ack_cycle", fat, (x_first && xr) ? L2 : L1);
    if (xr) chk("x_ack_cycle", xat, x_first ? L1 : L2);
    step();
    chk_idle_outputs("post_xact");
  endtask
  initial begin
    int k;
    logic [4:0] fa, xa;
    logic fr, xr;
    bus.f_req = 0; bus.f_addr = '0; bus.x_req = 0; bus.x_r_wbar = 1; bus.x_addr = '0; bus.x_wdata = '0;
    model_reset();
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    chk_idle_outputs("reset");
    chk("reset_ao", bus.mem_ao, 0);
    chk("reset_rw", bus.mem_r_wbar, 1);
    chk("reset_wdata", bus.mem_wdata, 0);
    xact(1, 0, 1, 5'h04, 5'h00, 16'h0);
    chk("fetch_word4", bus.f_rdata, 16'hA5C3);
    xact(0, 1, 0, 5'h00, 5'h1F, 16'h1234);
    xact(0, 1, 1, 5'h00, 5'h1F, 16'h0);
    chk("x_read_back", bus.x_rdata, 16'h1234);
    chk("f_rdata_kept", bus.f_rdata, 16'hA5C3);
    xact(1, 1, 1, 5'h1F, 5'h02, 16'h0);
    xact(1, 1, 0, 5'h07, 5'h07, 16'hBEEF);
    for (int i = 0; i < 24; i++) begin
      fr = 1'($urandom);
      xr = 1'($urandom);
      if (!fr && !xr) xr = 1'b1;
      xact(fr, xr, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
    end
    fa = 5'($urandom);
    xa = 5'($urandom);
    bus.f_addr = fa; bus.x_addr = xa; bus.x_r_wbar = 1'b1;
    bus.f_req = 1'b1; bus.x_req = 1'b1;
    k = 0;
    for (int n = 0; n < 8 * (ML + 3) + 10 && k < 8; n++) begin
      step();
      if (bus.f_ack || bus.x_ack) begin
        logic exp_x;
        exp_x = !(FAIR && mfair == FL);
        mfair = exp_x ? mfair + 1 : 0;
        chk("fair_seq", bus.x_ack, exp_x);
        if (bus.x_ack) begin m_xrd = ref_mem[xa]; chk("fair_x_rdata", bus.x_rdata, m_xrd); end
        if (bus.f_ack) begin m_frd = ref_mem[fa]; chk("fair_f_rdata", bus.f_rdata, m_frd); end
        k++;
        if (k == 8) begin bus.f_req = 1'b0; bus.x_req = 1'b0; end
      end
    end
    chk("fair_grants", k, 8);
    bus.f_req = 1'b0; bus.x_req = 1'b0;
    mfair = 0;
    step();
    chk_idle_outputs("post_fair");
    bus.f_addr = 5'h04; bus.f_req = 1'b1;
    step(); step();
    chk("abort_in_access", bus.mem_en, 1);
    reset = 1'b1; bus.f_req = 1'b0;
    model_reset();
    step();
    reset = 1'b0;
    chk_idle_outputs("abort");
    chk("abort_ao", bus.mem_ao, 0);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("abort_no_ack", bus.f_ack | bus.x_ack, 0);
    end
    xact(1, 1, 1, 5'h04, 5'h04, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (address ao, data edb, r_wbar) between two requesters: the instruction-fetch path (read-only, loads irf) and the execution microsequencer (operand reads, stores, push/pop).
- Sequences each access through a fixed-latency wait counter and returns a one-cycle acknowledge to the owner.
- Sits between the fetch/execute control logic and the 32x16 memory array.

Parameters:
ADDR_W, 5, memory address width (32 words)
DATA_W, 16, memory data width
MEM_LAT, 1, extra wait cycles per access (0..15)
FAIR_LIMIT, 3, consecutive execute grants allowed while fetch is pending (used only with ARB_FAIR_EN)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
f_req  input  1  fetch request, level, held until f_ack
f_addr  input  ADDR_W  fetch address (pc)
f_ack  output  1  one-cycle fetch completion pulse
f_rdata  output  DATA_W  fetched word, valid from the f_ack cycle until the next fetch completes
x_req  input  1  execute request, level, held until x_ack
x_r_wbar  input  1  1 = read, 0 = write
x_addr  input  ADDR_W  execute address
x_wdata  input  DATA_W  execute write data
x_ack  output  1  one-cycle execute completion pulse
x_rdata  output  DATA_W  execute read word, valid from the x_ack cycle until the next execute read completes
mem_en  output  1  memory access strobe
mem_r_wbar  output  1  memory direction
mem_ao  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data (edb out)
mem_rdata  input  DATA_W  memory read data (edb in)
busy  output  1  high while in ACCESS or ACK

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, mem_en=0, mem_r_wbar=1, mem_ao=0, mem_wdata=0, f_ack=0, x_ack=0, f_rdata=0, x_rdata=0, busy=0, wait counter=0, fairness counter=0.
- Reset asserted mid-access aborts the access immediately; no ack is issued.

FSM states: IDLE, ACCESS, ACK.

- IDLE:
  - If any request is high: select the owner, latch its address, direction and write data onto the mem_* outputs, set mem_en=1, load cnt=MEM_LAT, go to ACCESS.
  - A fetch grant always drives mem_r_wbar=1 and mem_wdata=0.
  - If no request is high: stay in IDLE.
- ACCESS:
  - If cnt != 0: decrement cnt.
  - If cnt == 0:
    - If the access is a read, capture mem_rdata into the owner's rdata.
    - Set mem_en=0 and set the owner's ack=1.
    - Go to ACK.
  - mem_en is high for exactly MEM_LAT+1 cycles.
  - mem_ao, mem_r_wbar and mem_wdata are stable throughout ACCESS.
- ACK: clear ack, go to IDLE.

Latency and handshake:
- Latency from request sampled in IDLE to ack high is MEM_LAT+2 cycles.
- Back-to-back accesses: a new grant earliest MEM_LAT+3 cycles after the previous one.
- Request inputs are sampled only in IDLE. Address and data changes after the grant are ignored.
- A request dropped mid-access: the access completes and ack still pulses.
- A request still high in the cycle after ack is treated as a new request.
- f_ack and x_ack are never high in the same cycle.

Arbitration:
- Both requests high in IDLE: execute wins (strict priority), subject to the optional fairness feature.

Data and addressing rules:
- A write leaves the rdata outputs unchanged.
- Addresses are used as-is. Wrap-around or out-of-range decoding belongs to the memory.

Optional Feature:
ARB_FAIR_EN
- Defined:
  - A fairness counter increments on each execute grant made while f_req is high.
  - When the counter reaches FAIR_LIMIT and f_req is high, the next grant goes to fetch even if x_req is high.
  - The counter clears on any fetch grant, and on any execute grant made while f_req is low.
- Undefined: strict execute priority; fetch can starve indefinitely. No counter is instantiated.

Test Plan:
- Reset, then idle 5 cycles -> all outputs at reset values; busy=0, mem_en=0.
- MEM_LAT=1; f_req=1, f_addr=5'h04, memory word 4 = 16'hA5C3 -> mem_en high 2 cycles with mem_ao=4 and mem_r_wbar=1; f_ack pulses on cycle 3 after sampling; f_rdata=16'hA5C3; x_ack stays 0.
- Execute write x_addr=5'h1F, x_wdata=16'h1234, x_r_wbar=0, then execute read of 5'h1F -> first access: mem_r_wbar=0 and mem_wdata=16'h1234; second access returns x_rdata=16'h1234; f_rdata unchanged.
- f_req and x_req rise in the same cycle -> execute is granted first; fetch is granted at the IDLE immediately after x_ack; ack order is x_ack then f_ack.
- ARB_FAIR_EN, FAIR_LIMIT=3, x_req and f_req held high continuously -> grant sequence X,X,X,F,X,X,X,F. Without the macro: only X grants.
- reset asserted during the second ACCESS cycle of a read -> next cycle state=IDLE, mem_en=0, no ack pulse, rdata=0.
